ssd_capture: RTL and testbench
==============================

Name: ssd_capture

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Samples a time-multiplexed 4-digit seven-segment bus (active-low digit enables plus active-low segments/dot) and reconstructs per-digit hex nibbles, dot bits and pattern-error flags.
- Publishes a complete 4-digit frame with a one-cycle valid pulse.
- Used for loopback self-check of the display path and for observing board display traffic.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (range 2..255).
- CNT_W, 8, width of the stability counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ssd_ctl, input, 4, digit enables, active-low; bit i low selects digit i.
- segs, input, 8, segs[7:1] = segments a..g (active-low), segs[0] = dot (active-low, 0 = lit).
- hex_out, output, 16, frame nibbles; digit i at [4i+3:4i].
- dots, output, 4, 1 = dot lit on digit i.
- err, output, 4, 1 = digit i carried an unrecognised segment pattern.
- frame_valid, output, 1, one-cycle pulse when hex_out/dots/err update.

Behaviour:
- Reset (async, rst_n=0): hex_out=0, dots=0, err=0, frame_valid=0, seen mask=0, slots=0, state=IDLE, counter=0. Input registers reset to ctl=4'hF, segs=8'hFF. Reset mid-capture discards all partial frame data.
- Input stage: ssd_ctl/segs are registered (ctl_q/segs_q), then delayed once more (ctl_p/segs_p) for change detection. A "change" is ctl_q != ctl_p or segs_q != segs_p.
- Valid select: ctl_q has exactly one bit low. All-high or multiple-low is not a valid select.
- States:
  - IDLE: no valid select. Goes to SETTLE on a change into a valid select.
  - SETTLE: counter increments each unchanged cycle. Any change resets the counter to 0, staying in SETTLE if the select is valid, else going to IDLE. When the counter reaches STABLE_CYCLES-1 with no change, the state captures and moves to HOLD.
  - HOLD: no further capture. Any change resets the counter and goes to SETTLE or IDLE as above.
- Timing: pins constant from before edge n means the capture occurs at edge n+1+STABLE_CYCLES (n+5 at default). Holding fewer cycles than this never captures.
- Capture:
  - Decode segs_q[7:1] against the 16 encoder patterns (0..9, A, b, C, d, E, F).
  - Match: slot nibble = value, err bit = 0.
  - No match: nibble = 0, err bit = 1.
  - Dot bit = ~segs_q[0].
  - Set seen[i]. Recapturing an already-seen digit overwrites its slot.
- Frame: on the edge after seen becomes 4'hF:
  - hex_out, dots and err load from the slots.
  - frame_valid = 1 for exactly one cycle.
  - seen clears to 0.
- Simultaneous capture and frame publish: publish uses slot values before that capture. The new capture's slot write proceeds, and seen takes only the new bit (not 0).
- Outputs hold between frames. No timeout: a partial frame waits indefinitely.

Decomposition:
- Shared package ssd_pkg:
  - SS_0..SS_F 7-bit active-low segment constants (shared with the encoder).
  - NUM_DIGITS=4.
  - State enum IDLE/SETTLE/HOLD.
- Sub-module ssd_decode: combinational 7-bit pattern to {valid, nibble[3:0]}, the exact inverse of the encoder table.

Test Plan:
- Reset: assert rst_n=0 mid-SETTLE, release. Required: all outputs 0, no frame_valid until 4 fresh captures.
- Normal scan: ctl 1110/1101/1011/0111 with segs {SS_1,1}, {SS_2,1}, {SS_3,0}, {SS_4,1}, each held 8 cycles. Required: single frame_valid pulse, hex_out=16'h4321, dots=4'b0100, err=0.
- Glitch filter: digit 0 held only 3 cycles, then ctl=4'hF. Required: seen unchanged, no frame_valid; with 5 cycles, capture occurs exactly at n+5.
- Bad pattern: digit 2 segs=8'b1111111_0, others valid (hex 0). Required: err=4'b0100, hex_out[11:8]=0, dots[2]=1.
- Illegal select: ctl=4'b1100 held 20 cycles. Required: no capture, state IDLE, outputs unchanged.
- Continuous scan of F,E,d,C at 6 cycles/digit for 3 rounds. Required: frame_valid every 24 cycles, hex_out=16'hCdEF (0xCDEF), no gaps.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display path: the active-low
// segment patterns used by the encoder, the digit count and the capture
// state encoding.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low segment patterns, bit 6 = segment a ... bit 0 = segment g.
    localparam logic [6:0] SS_0 = 7'h01;
    localparam logic [6:0] SS_1 = 7'h4F;
    localparam logic [6:0] SS_2 = 7'h12;
    localparam logic [6:0] SS_3 = 7'h06;
    localparam logic [6:0] SS_4 = 7'h4C;
    localparam logic [6:0] SS_5 = 7'h24;
    localparam logic [6:0] SS_6 = 7'h20;
    localparam logic [6:0] SS_7 = 7'h0F;
    localparam logic [6:0] SS_8 = 7'h00;
    localparam logic [6:0] SS_9 = 7'h04;
    localparam logic [6:0] SS_A = 7'h08;
    localparam logic [6:0] SS_B = 7'h60;
    localparam logic [6:0] SS_C = 7'h31;
    localparam logic [6:0] SS_D = 7'h42;
    localparam logic [6:0] SS_E = 7'h30;
    localparam logic [6:0] SS_F = 7'h38;

    // Capture state encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SETTLE = 2'd1;
    localparam state_t HOLD   = 2'd2;

    // True when exactly one active-low digit enable is asserted.
    function automatic logic one_low(input logic [NUM_DIGITS-1:0] ctl);
        logic [NUM_DIGITS-1:0] inv;
        inv = ~ctl;
        return (inv != '0) && ((inv & (inv - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/ssd_decode.sv
// Seven-segment pattern to hex nibble; exact inverse of the encoder table.
// Unrecognised patterns report valid=0 with nibble 0.
module ssd_decode
    import ssd_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       valid,
    output logic [3:0] nibble
);

    // Table lookup against the sixteen encoder patterns.
    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            SS_0:    nibble = 4'h0;
            SS_1:    nibble = 4'h1;
            SS_2:    nibble = 4'h2;
            SS_3:    nibble = 4'h3;
            SS_4:    nibble = 4'h4;
            SS_5:    nibble = 4'h5;
            SS_6:    nibble = 4'h6;
            SS_7:    nibble = 4'h7;
            SS_8:    nibble = 4'h8;
            SS_9:    nibble = 4'h9;
            SS_A:    nibble = 4'hA;
            SS_B:    nibble = 4'hB;
            SS_C:    nibble = 4'hC;
            SS_D:    nibble = 4'hD;
            SS_E:    nibble = 4'hE;
            SS_F:    nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_capture.sv
// Seven-segment bus capture: samples a multiplexed 4-digit display bus,
// waits for each digit to be stable, decodes it and publishes complete
// frames with a one-cycle frame_valid pulse.
module ssd_capture
    import ssd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ssd_ctl,
    input  logic [7:0]  segs,
    output logic [15:0] hex_out,
    output logic [3:0]  dots,
    output logic [3:0]  err,
    output logic        frame_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       ctl_q, ctl_p;
    logic [7:0]       segs_q, segs_p;
    logic             change;
    logic             sel_valid;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             capture;
    logic [3:0]       cap_bits;
    logic             dec_valid;
    logic [3:0]       dec_nibble;
    logic [15:0]      slot_hex;
    logic [3:0]       slot_dot;
    logic [3:0]       slot_err;
    logic [3:0]       seen;

    // Register the pins, then keep one more copy for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q  <= 4'hF;
            segs_q <= 8'hFF;
            ctl_p  <= 4'hF;
            segs_p <= 8'hFF;
        end else begin
            ctl_q  <= ssd_ctl;
            segs_q <= segs;
            ctl_p  <= ctl_q;
            segs_p <= segs_q;
        end
    end

    assign change    = (ctl_q != ctl_p) || (segs_q != segs_p);
    assign sel_valid = one_low(ctl_q);

    // SETTLE is only entered on a valid select and left on any change, so
    // the select is still valid when the counter expires.
    assign capture = (state == SETTLE) && !change && (cnt == CNT_LAST);

    // Stability tracking: count unchanged cycles, capture once, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (change && sel_valid)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (change) begin
                        cnt   <= '0;
                        state <= sel_valid ? SETTLE : IDLE;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    cnt <= '0;
                    if (change)
                        state <= sel_valid ? SETTLE : IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    ssd_decode u_decode (
        .pattern (segs_q[7:1]),
        .valid   (dec_valid),
        .nibble  (dec_nibble)
    );

    // Per-digit slots: written only by a capture addressing that digit.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign cap_bits[gi] = capture & ~ctl_q[gi];

            // Store decoded nibble, error flag and dot for digit gi.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_hex[4*gi +: 4] <= 4'h0;
                    slot_err[gi]        <= 1'b0;
                    slot_dot[gi]        <= 1'b0;
                end else if (cap_bits[gi]) begin
                    slot_hex[4*gi +: 4] <= dec_valid ? dec_nibble : 4'h0;
                    slot_err[gi]        <= ~dec_valid;
                    slot_dot[gi]        <= ~segs_q[0];
                end
            end
        end
    endgenerate

    // Publish the slots once every digit has been seen; a capture on the
    // publishing edge starts the next frame rather than being lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out     <= 16'h0;
            dots        <= 4'h0;
            err         <= 4'h0;
            frame_valid <= 1'b0;
            seen        <= 4'h0;
        end else begin
            frame_valid <= 1'b0;
            if (seen == 4'hF) begin
                hex_out     <= slot_hex;
                dots        <= slot_dot;
                err         <= slot_err;
                frame_valid <= 1'b1;
                seen        <= cap_bits;
            end else begin
                seen <= seen | cap_bits;
            end
        end
    end

endmodule

// File: tb/tb_ssd_capture.sv
// Testbench for ssd_capture: directed scenarios plus randomized bus traffic,
// compared every cycle against a run-length based reference model.
module tb_ssd_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ssd_ctl;
    logic [7:0]  segs;
    logic [15:0] hex_out;
    logic [3:0]  dots;
    logic [3:0]  err;
    logic        frame_valid;

    ssd_capture #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ssd_ctl     (ssd_ctl),
        .segs        (segs),
        .hex_out     (hex_out),
        .dots        (dots),
        .err         (err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Independent copy of the display table (active-low a..g).
    logic [6:0] pat [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fv_count    = 0;
    int fv_cyc [$];

    // Reference model: a digit is captured when the sampled pins have held one
    // value for exactly S+1 consecutive edges and that value selects one digit.
    logic [11:0] m_last;
    int          m_run;
    logic [3:0]  m_seen;
    logic [3:0]  m_nib [4];
    logic        m_dot [4];
    logic        m_err [4];
    logic [15:0] m_hex;
    logic [3:0]  m_dots, m_errs;
    logic        m_fv;
    int          m_d, m_k;
    logic [3:0]  m_new;

    function automatic int low_index(input logic [3:0] c);
        int n = 0;
        int p = -1;
        for (int i = 0; i < 4; i++)
            if (!c[i]) begin
                n++;
                p = i;
            end
        return (n == 1) ? p : -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = {4'hF, 8'hFF};
            m_run  = 1;
            m_seen = 4'h0;
            m_hex  = 16'h0;
            m_dots = 4'h0;
            m_errs = 4'h0;
            m_fv   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_nib[i] = 4'h0;
                m_dot[i] = 1'b0;
                m_err[i] = 1'b0;
            end
        end else begin
            m_fv  = 1'b0;
            m_new = 4'h0;
            if (m_seen == 4'hF) begin
                for (int i = 0; i < 4; i++) begin
                    m_hex[4*i +: 4] = m_nib[i];
                    m_dots[i]       = m_dot[i];
                    m_errs[i]       = m_err[i];
                end
                m_fv   = 1'b1;
                m_seen = 4'h0;
            end
            m_d = low_index(m_last[11:8]);
            if (m_run == S + 1 && m_d >= 0) begin
                m_k = -1;
                for (int v = 0; v < 16; v++)
                    if (pat[v] == m_last[7:1]) m_k = v;
                m_nib[m_d] = (m_k >= 0) ? 4'(m_k) : 4'h0;
                m_err[m_d] = (m_k < 0);
                m_dot[m_d] = ~m_last[0];
                m_new[m_d] = 1'b1;
            end
            m_seen = m_seen | m_new;
            if ({ssd_ctl, segs} == m_last) begin
                if (m_run < 1000) m_run = m_run + 1;
            end else begin
                m_last = {ssd_ctl, segs};
                m_run  = 1;
            end
        end
    end

    always @(posedge clk) cyc++;

    // Per-cycle compare against the model, plus a one-line log per frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            vectors++;
            if (hex_out !== m_hex || dots !== m_dots || err !== m_errs || frame_valid !== m_fv) begin
                miscompares++;
                $display("FAIL cycle %0d model: got hex=%h dots=%b err=%b fv=%b, required hex=%h dots=%b err=%b fv=%b",
                         cyc, hex_out, dots, err, frame_valid, m_hex, m_dots, m_errs, m_fv);
            end
            if (frame_valid === 1'b1) begin
                fv_count++;
                fv_cyc.push_back(cyc);
                $display("frame @%0d: hex=%h dots=%b err=%b", cyc, hex_out, dots, err);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Called at a falling edge; holds the pins for n clock cycles.
    task automatic drive(input logic [3:0] c, input logic [7:0] s, input int n);
        ssd_ctl = c;
        segs    = s;
        repeat (n) @(negedge clk);
    endtask

    int fc;
    logic [3:0] rc;
    logic [7:0] rs;

    initial begin
        rst_n   = 1'b0;
        ssd_ctl = 4'hF;
        segs    = 8'hFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 8'hFF, 2);

        // Reset in the middle of a frame discards the partial data.
        drive(4'b1101, {pat[1], 1'b1}, 8);
        drive(4'b1011, {pat[2], 1'b1}, 8);
        drive(4'b0111, {pat[3], 1'b1}, 8);
        drive(4'b1110, {pat[5], 1'b1}, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rst_hex", 32'(hex_out), 32'h0);
        check("rst_dots", 32'(dots), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        fc = fv_count;
        drive(4'b1110, {pat[1], 1'b1}, 8);
        drive(4'b1101, {pat[1], 1'b1}, 8);
        drive(4'b1011, {pat[1], 1'b1}, 8);
        check("rst_no_frame", 32'(fv_count - fc), 32'd0);
        drive(4'b0111, {pat[1], 1'b1}, 8);
        check("rst_fresh_frame", 32'(fv_count - fc), 32'd1);

        // Normal scan.
        fc = fv_count;
        drive(4'b1110, {pat[1], 1'b1}, 8);
        drive(4'b1101, {pat[2], 1'b1}, 8);
        drive(4'b1011, {pat[3], 1'b0}, 8);
        drive(4'b0111, {pat[4], 1'b1}, 8);
        check("scan_pulses", 32'(fv_count - fc), 32'd1);
        check("scan_hex", 32'(hex_out), 32'h4321);
        check("scan_dots", 32'(dots), 32'b0100);
        check("scan_err", 32'(err), 32'h0);
        check("model_scan_hex", 32'(m_hex), 32'h4321);

        // Glitch filter: 3 cycles never captures, 5 cycles captures at n+5.
        fc = fv_count;
        drive(4'b1110, {pat[5], 1'b1}, 3);
        drive(4'hF, 8'hFF, 10);
        drive(4'b1101, {pat[6], 1'b1}, 8);
        drive(4'b1011, {pat[7], 1'b1}, 8);
        drive(4'b0111, {pat[8], 1'b1}, 8);
        check("glitch_no_frame", 32'(fv_count - fc), 32'd0);
        drive(4'b1110, {pat[9], 1'b1}, 5);
        ssd_ctl = 4'hF;
        segs    = 8'hFF;
        @(negedge clk);
        check("glitch_fv_early", 32'(frame_valid), 32'd0);
        @(negedge clk);
        check("glitch_fv_exact", 32'(frame_valid), 32'd1);
        check("glitch_hex", 32'(hex_out), 32'h8769);
        drive(4'hF, 8'hFF, 4);

        // Unrecognised pattern on digit 2.
        drive(4'b1110, {pat[0], 1'b1}, 8);
        drive(4'b1101, {pat[0], 1'b1}, 8);
        drive(4'b1011, 8'b1111111_0, 8);
        drive(4'b0111, {pat[0], 1'b1}, 8);
        check("bad_err", 32'(err), 32'b0100);
        check("bad_hex", 32'(hex_out), 32'h0000);
        check("bad_dots", 32'(dots), 32'b0100);
        check("model_bad_err", 32'(m_errs), 32'b0100);

        // Two digits selected at once is ignored.
        fc = fv_count;
        drive(4'b1100, {pat[3], 1'b1}, 20);
        drive(4'hF, 8'hFF, 2);
        check("illegal_no_frame", 32'(fv_count - fc), 32'd0);
        check("illegal_hex", 32'(hex_out), 32'h0000);
        check("illegal_err", 32'(err), 32'b0100);

        // Continuous scan, 6 cycles per digit, 3 rounds.
        fc = fv_count;
        for (int r = 0; r < 3; r++) begin
            drive(4'b1110, {pat[15], 1'b1}, 6);
            drive(4'b1101, {pat[14], 1'b1}, 6);
            drive(4'b1011, {pat[13], 1'b1}, 6);
            drive(4'b0111, {pat[12], 1'b1}, 6);
        end
        drive(4'hF, 8'hFF, 4);
        check("cont_pulses", 32'(fv_count - fc), 32'd3);
        check("cont_hex", 32'(hex_out), 32'hCDEF);
        if (fv_cyc.size() >= 3) begin
            check("cont_gap1", 32'(fv_cyc[fv_cyc.size()-1] - fv_cyc[fv_cyc.size()-2]), 32'd24);
            check("cont_gap2", 32'(fv_cyc[fv_cyc.size()-2] - fv_cyc[fv_cyc.size()-3]), 32'd24);
        end

        // Randomized traffic with occasional resets.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 9) < 8) begin
                rc = 4'hF;
                rc[$urandom_range(0, 3)] = 1'b0;
            end else begin
                rc = 4'($urandom);
            end
            if ($urandom_range(0, 3) != 0)
                rs = {pat[$urandom_range(0, 15)], 1'($urandom)};
            else
                rs = 8'($urandom);
            drive(rc, rs, $urandom_range(1, 9));
        end
        drive(4'hF, 8'hFF, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
